// File: rtl/k_rpack_t1.sv
// k_rpack_t1: read-side drain engine for the 2-deep CDC FIFO.
// Pops data_size-bit words via rrdy/rget and packs PACK of them (lane 0 in
// the LSBs) into one wide word presented on a registered valid/ready stream.
// A flush pulse forces out a partially filled word.
// Optional feature macro: K_RPACK_PARITY_EN adds per-lane even parity m_par.
// Ports:
//   rclk, rrst_n        read-domain clock, synchronous active-low reset
//   rdata, rrdy, rget   FIFO read port (rget is combinational)
//   flush               single-cycle partial-word request
//   m_data, m_cnt       packed word and number of valid lanes
//   m_valid, m_ready    output stream handshake
//   m_par               per-lane parity (K_RPACK_PARITY_EN only)
module k_rpack_t1 #(
   parameter int unsigned data_size = 8,
   parameter int unsigned PACK      = 4,
   parameter int unsigned CNT_W     = 3
) (
   input  logic                      rclk,
   input  logic                      rrst_n,
   input  logic [data_size-1:0]      rdata,
   input  logic                      rrdy,
   output logic                      rget,
   input  logic                      flush,
   output logic [data_size*PACK-1:0] m_data,
   output logic [CNT_W-1:0]          m_cnt,
   output logic                      m_valid,
   input  logic                      m_ready
`ifdef K_RPACK_PARITY_EN
   ,
   output logic [PACK-1:0]           m_par
`endif
);

   localparam int unsigned IDX_W = (PACK > 1) ? $clog2(PACK) : 1;
   localparam int unsigned W     = data_size * PACK;

   typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

   state_t           state, state_next;
   logic [IDX_W-1:0] idx, idx_next;
   logic [W-1:0]     data_next;
   logic [CNT_W-1:0] cnt_next;
   logic             valid_next;

   // Pop whenever filling, or when the presented word is being accepted.
   assign rget = rrst_n & rrdy & ((state == FILL) | ((state == HOLD) & m_ready));

   // Next-state, lane capture and output-word computation.
   always_comb begin
      state_next = state;
      idx_next   = idx;
      data_next  = m_data;
      cnt_next   = m_cnt;
      case (state)
         FILL: begin
            if (rget) begin
               for (int i = 0; i < int'(PACK); i++) begin
                  if (idx == IDX_W'(i)) data_next[i*data_size +: data_size] = rdata;
               end
               // Last lane or flush with a pop: popped word is included.
               if ((idx == IDX_W'(PACK - 1)) || flush) begin
                  state_next = HOLD;
                  cnt_next   = CNT_W'(idx) + CNT_W'(1);
                  idx_next   = '0;
               end else begin
                  idx_next = idx + IDX_W'(1);
               end
            end else if (flush && (idx != '0)) begin
               state_next = HOLD;
               cnt_next   = CNT_W'(idx);
               idx_next   = '0;
            end
         end
         HOLD: begin
            // Handshake: start a fresh cleared word, overlapping its first pop.
            if (m_ready) begin
               state_next = FILL;
               cnt_next   = '0;
               data_next  = '0;
               idx_next   = '0;
               if (rget) begin
                  data_next[data_size-1:0] = rdata;
                  idx_next                 = IDX_W'(1);
               end
            end
         end
         default: begin
            state_next = FILL;
         end
      endcase
      valid_next = (state_next == HOLD);
   end

   // State and registered outputs.
   always_ff @(posedge rclk) begin
      if (!rrst_n) begin
         state   <= FILL;
         idx     <= '0;
         m_data  <= '0;
         m_cnt   <= '0;
         m_valid <= 1'b0;
      end else begin
         state   <= state_next;
         idx     <= idx_next;
         m_data  <= data_next;
         m_cnt   <= cnt_next;
         m_valid <= valid_next;
      end
   end

`ifdef K_RPACK_PARITY_EN
   logic [PACK-1:0] par_next;

   // Parity tracks the word being registered; cleared lanes give 0.
   always_comb begin
      par_next = '0;
      for (int i = 0; i < int'(PACK); i++) begin
         par_next[i] = ^data_next[i*data_size +: data_size];
      end
   end

   always_ff @(posedge rclk) begin
      if (!rrst_n) m_par <= '0;
      else         m_par <= par_next;
   end
`endif

endmodule

// File: tb/tb_k_rpack_t1.sv
// Self-checking bench for k_rpack_t1: directed steps followed by a random
// phase, scored against a queue-based packet model.
module tb_k_rpack_t1;
   localparam int unsigned DS    = 8;
   localparam int unsigned PACK  = 4;
   localparam int unsigned CNT_W = 3;

   logic              rclk = 1'b0;
   logic              rrst_n = 1'b0;
   logic [DS-1:0]     rdata = '0;
   logic              rrdy = 1'b0;
   logic              rget;
   logic              flush = 1'b0;
   logic [DS*PACK-1:0] m_data;
   logic [CNT_W-1:0]  m_cnt;
   logic              m_valid;
   logic              m_ready = 1'b1;
`ifdef K_RPACK_PARITY_EN
   logic [PACK-1:0]   m_par;
`endif

   k_rpack_t1 #(.data_size(DS), .PACK(PACK), .CNT_W(CNT_W)) dut (
      .rclk(rclk), .rrst_n(rrst_n), .rdata(rdata), .rrdy(rrdy), .rget(rget),
      .flush(flush), .m_data(m_data), .m_cnt(m_cnt), .m_valid(m_valid),
      .m_ready(m_ready)
`ifdef K_RPACK_PARITY_EN
      , .m_par(m_par)
`endif
   );

   always #5 rclk = ~rclk;

   int n_assert = 0;
   int n_fail   = 0;

   // Model: FIFO contents, lanes of the word being gathered, presented word.
   logic [DS-1:0]      fifo[$];
   logic [DS-1:0]      lanes[$];
   bit                 hold = 0;
   logic [DS*PACK-1:0] exp_data = '0;
   logic [CNT_W-1:0]   exp_cnt = '0;
   logic [PACK-1:0]    exp_par = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic emit();
      exp_data = '0;
      exp_par  = '0;
      foreach (lanes[i]) begin
         exp_data[i*DS +: DS] = lanes[i];
         exp_par[i]           = ^lanes[i];
      end
      exp_cnt = CNT_W'(lanes.size());
      lanes.delete();
      hold = 1;
   endtask

   // One clock: drive FIFO side, check at negedge, advance model, return at posedge+1.
   task automatic tick();
      bit er;
      bit was_hold;
      rrdy  = (fifo.size() > 0);
      rdata = rrdy ? fifo[0] : '0;
      @(negedge rclk);
      er = rrst_n && rrdy && (!hold || m_ready);
      chk("rget", 64'(rget), 64'(er));
      chk("m_valid", 64'(m_valid), 64'(hold));
      if (hold) begin
         chk("m_data", 64'(m_data), 64'(exp_data));
         chk("m_cnt", 64'(m_cnt), 64'(exp_cnt));
`ifdef K_RPACK_PARITY_EN
         chk("m_par", 64'(m_par), 64'(exp_par));
`endif
      end
      if (!rrst_n) begin
         lanes.delete();
         hold = 0;
      end else begin
         was_hold = hold;
         if (hold && m_ready) hold = 0;
         if (er) lanes.push_back(fifo.pop_front());
         if (!was_hold && ((lanes.size() == PACK) || (flush && lanes.size() > 0))) emit();
      end
      @(posedge rclk);
      #1;
      flush = 1'b0;
   endtask

   task automatic do_reset();
      rrst_n = 1'b0;
      fifo.delete();
      fifo.push_back(8'hEE);
      for (int i = 0; i < 3; i++) tick();
      chk("rst_data", 64'(m_data), 64'h0);
      chk("rst_cnt", 64'(m_cnt), 64'h0);
      chk("rst_valid", 64'(m_valid), 64'h0);
      fifo.delete();
      rrst_n = 1'b1;
   endtask

   initial begin
      #1;
      // Reset with FIFO non-empty.
      m_ready = 1'b1;
      do_reset();

      // Full pack with m_ready high.
      fifo = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) tick();
      chk("full_data", 64'(m_data), 64'h44332211);
      chk("full_cnt", 64'(m_cnt), 64'd4);
      chk("full_valid", 64'(m_valid), 64'd1);
      tick();
      chk("full_valid_drop", 64'(m_valid), 64'd0);

      // Backpressure: 0x55 waits until m_ready rises.
      do_reset();
      m_ready = 1'b0;
      fifo = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h55};
      for (int i = 0; i < 4; i++) tick();
      tick();
      chk("bp_held", 64'(m_data), 64'h04030201);
      chk("bp_fifo_kept", 64'(fifo.size()), 64'd1);
      m_ready = 1'b1;
      tick();
      chk("bp_lane0", 64'(m_data), 64'h55);
      chk("bp_valid", 64'(m_valid), 64'd0);

      // Flush of a two-word partial, then flush at idx 0.
      do_reset();
      fifo = '{8'hA1, 8'hB2};
      m_ready = 1'b0;
      tick(); tick();
      flush = 1'b1;
      tick();
      chk("fl_data", 64'(m_data), 64'h0000B2A1);
      chk("fl_cnt", 64'(m_cnt), 64'd2);
      m_ready = 1'b1;
      tick();
      flush = 1'b1;
      tick();
      tick();
      chk("fl_empty", 64'(m_valid), 64'd0);

      // Flush with simultaneous pop.
      fifo.push_back(8'h07);
      tick();
      fifo.push_back(8'hC3);
      flush = 1'b1;
      m_ready = 1'b0;
      tick();
      chk("flpop_data", 64'(m_data), 64'h0000C307);
      chk("flpop_cnt", 64'(m_cnt), 64'd2);
      m_ready = 1'b1;
      tick();

      // Parity pattern, then a mid-packet reset.
      do_reset();
      m_ready = 1'b0;
      fifo = '{8'h01, 8'h03, 8'h07, 8'h00};
      for (int i = 0; i < 4; i++) tick();
`ifdef K_RPACK_PARITY_EN
      chk("par", 64'(m_par), 64'b0101);
`endif
      m_ready = 1'b1;
      tick();
      fifo = '{8'h09, 8'h0A};
      tick(); tick();
      do_reset();
`ifdef K_RPACK_PARITY_EN
      chk("rst_par", 64'(m_par), 64'h0);
`endif
      m_ready = 1'b0;
      fifo = '{8'h5C, 8'h6D, 8'h7E, 8'h8F};
      for (int i = 0; i < 4; i++) tick();
      chk("post_rst_data", 64'(m_data), 64'h8F7E6D5C);
      chk("post_rst_cnt", 64'(m_cnt), 64'd4);
      m_ready = 1'b1;
      tick();

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         if (fifo.size() < 2 && $urandom_range(0, 2) != 0) fifo.push_back(DS'($urandom));
         m_ready = ($urandom_range(0, 3) != 0);
         flush   = ($urandom_range(0, 5) == 0);
         rrst_n  = ($urandom_range(0, 199) != 0);
         tick();
      end
      rrst_n = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/k_rpack_t1.md
# k_rpack_t1

Read-side drain engine for the 2-deep clock-domain-crossing FIFO. It sits in the read clock domain, pops words through the FIFO's `rrdy`/`rget` read port, and packs `PACK` consecutive `data_size`-bit words into one wide word. The wide word is presented on a registered valid/ready master stream. A `flush` input forces out a partially filled wide word, so packet tails never stall in the packer.

## Interface
- `data_size`, default 8: width of one FIFO word.
- `PACK`, default 4: FIFO words per output word (≥2).
- `CNT_W`, default 3: width of `m_cnt`; must hold the value `PACK`.

Ports:
- `rclk`  in  1  read-domain clock; all state on rising edge.
- `rrst_n`  in  1  synchronous, active-low reset.
- `rdata`  in  data_size  FIFO read data; valid whenever `rrdy`=1.
- `rrdy`  in  1  FIFO holds at least one word.
- `rget`  out  1  pop strobe to FIFO; the word is consumed at the rising edge where `rget`=1.
- `flush`  in  1  single-cycle request to emit a partial word.
- `m_data`  out  data_size*PACK  packed word; lane 0 (first word popped) in the LSBs.
- `m_cnt`  out  CNT_W  number of valid lanes in `m_data`, from 1 to PACK.
- `m_valid`  out  1  `m_data`/`m_cnt` valid.
- `m_ready`  in  1  downstream accepts when `m_valid`=1.
- `m_par`  out  PACK  per-lane even parity. Present only with `K_RPACK_PARITY_EN`.

## Operation
- States:
  - FILL: accumulating; `m_valid`=0.
  - HOLD: word presented; `m_valid`=1.
- Lane index `idx` runs 0..PACK-1.
- Pop rule:
  - `rget` = `rrst_n` & `rrdy` & (FILL | (HOLD & `m_ready`)).
  - `rget` is combinational.
  - `rget` is never 1 while `rrdy`=0 or while `rrst_n`=0.
- Capture: on a pop edge, `rdata` goes into lane `idx`.
- FILL transitions:
  - Pop with `idx`=PACK-1 → HOLD, `m_cnt`=PACK, `idx`←0.
  - Pop with `idx`<PACK-1, no `flush` → stay in FILL, `idx`+1.
  - `flush` with `idx`>0 and no pop → HOLD, `m_cnt`=`idx`, `idx`←0.
  - `flush` and pop in the same cycle → the popped word is included. `m_cnt`=`idx`+1, then HOLD, `idx`←0.
  - `flush` with `idx`=0 and no pop → ignored. Empty words are never emitted.
- HOLD transitions:
  - Handshake (`m_valid`&`m_ready`) with no pop → FILL.
  - Handshake with pop → the new word is written into lane 0 of a cleared accumulator, `idx`←1, state FILL.
  - If PACK would complete on this pop, the same rules as FILL apply. This cannot happen for PACK≥2.
  - `flush` in HOLD is ignored and is not remembered.
- Unfilled lanes of a partial word read as 0.
- The accumulator is cleared whenever a new word starts.
- `m_data`, `m_cnt` and `m_par` are stable while `m_valid`=1 and `m_ready`=0.

## Timing
- Reset (`rrst_n`=0 at an edge) sets:
  - state FILL, `idx`=0
  - `m_valid`=0, `m_data`=0, `m_cnt`=0, `m_par`=0
  - `rget`=0 combinationally while reset is held.
- Reset mid-packet discards the partial word. Words already popped are lost; this is by design.
- Latency: `m_valid` rises on the edge that pops the PACK-th word. It is visible the cycle after that pop.
- Throughput:
  - One FIFO word per cycle.
  - The first pop of the next word overlaps the output handshake, so a steady stream with `m_ready`=1 sustains 1 word per cycle.
- `m_valid` drops on the edge after a handshake unless a new word completes on that same edge. That case is impossible for PACK≥2.
- No combinational path from `rdata` to any output.
- Paths from `m_ready` and `rrdy` to `rget` are combinational.

## Configuration
- Macro: `K_RPACK_PARITY_EN`.
- Defined:
  - Port `m_par` exists.
  - Bit i is the XOR of lane i of `m_data`. It is registered with `m_data` and is 0 for unfilled lanes.
- Undefined:
  - Port `m_par` and its logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset: hold `rrst_n`=0 with `rrdy`=1 for 3 cycles. Required: `rget`=0, `m_valid`=0, `m_data`=0, `m_cnt`=0.
- Full pack (PACK=4, `m_ready`=1): pop 0x11, 0x22, 0x33, 0x44 on consecutive cycles. Required: `m_data`=0x44332211, `m_cnt`=4, `m_valid` high for 1 cycle.
- Backpressure:
  - `m_ready`=0 after a full word; FIFO still has 0x55. Required: `rget`=0, `m_data` held.
  - Raise `m_ready`. Required: `rget`=1 in the same cycle, then `idx`=1 with lane 0=0x55.
- Flush:
  - After popping 0xA1, 0xB2, pulse `flush` with `rrdy`=0. Required: `m_data`=0x0000B2A1, `m_cnt`=2.
  - Pulse `flush` with `idx`=0. Required: no output.
- Flush with a simultaneous pop of 0xC3 at `idx`=1 (lane 0=0x07). Required: `m_data`=0x0000C307, `m_cnt`=2.
- Parity (`K_RPACK_PARITY_EN` defined): pack 0x01, 0x03, 0x07, 0x00. Required: `m_par`=4'b0101. Mid-packet reset then clears everything, and the next output starts at lane 0.
